// File: rtl/seq_pkg.sv
// Shared definitions for the bytecode sequencer: FSM states, opcode values
// and the per-opcode operand count.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_OPND,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_e;

  localparam logic [7:0] OP_ALU2 = 8'h02;
  localparam logic [7:0] OP_ALU1 = 8'h01;
  localparam logic [7:0] OP_STI  = 8'hC2;
  localparam logic [7:0] OP_MOV  = 8'hE2;
  localparam logic [7:0] OP_PRN  = 8'h81;
  localparam logic [7:0] OP_CALL = 8'hAA;
  localparam logic [7:0] OP_RET  = 8'h55;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  // Data memory location that receives every ALU result.
  localparam logic [7:0] RESULT_ADDR = 8'h02;

  function automatic logic [1:0] opnd_count(input logic [7:0] opc);
    case (opc)
      OP_ALU2:                 return 2'd3;
      OP_ALU1, OP_STI, OP_MOV: return 2'd2;
      OP_PRN, OP_CALL:         return 2'd1;
      default:                 return 2'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] opc);
    case (opc)
      OP_ALU2, OP_ALU1, OP_STI, OP_MOV,
      OP_PRN, OP_CALL, OP_RET, OP_HLT: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_dmem.sv
// 256x8 data memory: combinational read, synchronous write. Only the ALU
// result location has a defined reset value.
module seq_dmem
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [256];
  logic [7:0] res_q;

  // NOTE: the array has no reset so it maps onto plain RAM; the one word that
  // needs a known value after reset lives in its own resettable register.
  always_ff @(posedge clk) begin
    if (we && (waddr != RESULT_ADDR)) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              res_q <= 8'h00;
    else if (we && (waddr == RESULT_ADDR))   res_q <= wdata;
  end

  assign rdata = (raddr == RESULT_ADDR) ? res_q : mem_q[raddr];

endmodule

// File: rtl/bytecode_sequencer.sv
// Byte-code sequencer: fetches opcodes and operands from a synchronous ROM,
// drives an external ALU, and executes store/move/print/call/return.
module bytecode_sequencer
  import seq_pkg::*;
#(
  parameter int         IMEM_AW   = 8,
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_data,
  output logic [5:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  output logic [7:0]         result,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               running,
  output logic               halted,
  output logic               illegal
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] opc_q, opc_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] opnd0_q, opnd0_d;
  logic [7:0] opnd1_q, opnd1_d;
  logic [7:0] link_q, link_d;
  logic       link_valid_q, link_valid_d;
  logic [7:0] result_q, result_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [5:0] alu_op_q, alu_op_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;

  logic       dmem_we;
  logic [7:0] dmem_waddr, dmem_wdata, dmem_raddr, dmem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational block assigns a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = (cnt_q == 2'd0 && pc_q == HALT_ADDR) ? S_HALT : S_LOAD;
      S_LOAD:   state_d = (cnt_q == 2'd0) ? S_DECODE : S_OPND;
      S_DECODE: begin
        if (!is_legal(byte_q))               state_d = S_ERR;
        else if (byte_q == OP_HLT)           state_d = S_HALT;
        else if (opnd_count(byte_q) == 2'd0) state_d = S_EXEC;
        else                                 state_d = S_FETCH;
      end
      S_OPND:   state_d = (cnt_q == 2'd1) ? S_EXEC : S_FETCH;
      S_EXEC:   state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    running    = !(state_q inside {S_IDLE, S_HALT, S_ERR});
    halted     = (state_q == S_HALT);
    illegal    = (state_q == S_ERR);
    dmem_we    = 1'b0;
    dmem_waddr = opnd0_q;
    dmem_wdata = opnd1_q;
    dmem_raddr = (opc_q == OP_MOV) ? opnd1_q : opnd0_q;
    if (state_q == S_EXEC) begin
      case (opc_q)
        OP_ALU2, OP_ALU1: begin
          dmem_we    = 1'b1;
          dmem_waddr = RESULT_ADDR;
          dmem_wdata = alu_result;
        end
        OP_STI: dmem_we = 1'b1;
        OP_MOV: begin
          dmem_we    = 1'b1;
          dmem_wdata = dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    opc_d        = opc_q;
    byte_d       = byte_q;
    opnd0_d      = opnd0_q;
    opnd1_d      = opnd1_q;
    link_d       = link_q;
    link_valid_d = link_valid_q;
    result_d     = result_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    case (state_q)
      S_LOAD: begin
        byte_d = imem_data;
        pc_d   = pc_q + 8'd1;
      end
      S_DECODE: begin
        opc_d = byte_q;
        cnt_d = opnd_count(byte_q);
        idx_d = 2'd0;
      end
      S_OPND: begin
        cnt_d = cnt_q - 2'd1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd0) opnd0_d = byte_q;
        if (idx_q == 2'd1) opnd1_d = byte_q;
        // ALU operands go straight to the ALU port registers; ALU1 never
        // reaches index 2, so alu_b keeps its previous value.
        if (opc_q == OP_ALU2 || opc_q == OP_ALU1) begin
          case (idx_q)
            2'd0:    alu_op_d = byte_q[5:0];
            2'd1:    alu_a_d  = byte_q;
            default: alu_b_d  = byte_q;
          endcase
        end
      end
      S_EXEC: begin
        case (opc_q)
          OP_ALU2, OP_ALU1: result_d = alu_result;
          OP_STI:           result_d = opnd1_q;
          OP_MOV:           result_d = dmem_rdata;
          OP_PRN: begin
            out_valid_d = 1'b1;
            out_data_d  = dmem_rdata;
          end
          OP_CALL: begin
            link_d       = pc_q - 8'd1;
            link_valid_d = 1'b1;
            pc_d         = opnd0_q;
          end
          OP_RET: begin
            if (link_valid_q) begin
              pc_d         = link_q + 8'd1;
              link_valid_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= 8'h00;
      cnt_q        <= 2'd0;
      idx_q        <= 2'd0;
      opc_q        <= 8'h00;
      byte_q       <= 8'h00;
      opnd0_q      <= 8'h00;
      opnd1_q      <= 8'h00;
      link_q       <= 8'h00;
      link_valid_q <= 1'b0;
      result_q     <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      alu_op_q     <= 6'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      opc_q        <= opc_d;
      byte_q       <= byte_d;
      opnd0_q      <= opnd0_d;
      opnd1_q      <= opnd1_d;
      link_q       <= link_d;
      link_valid_q <= link_valid_d;
      result_q     <= result_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  seq_dmem u_dmem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (dmem_raddr),
    .rdata (dmem_rdata)
  );

  assign imem_addr = IMEM_AW'(pc_q);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Directed bench for bytecode_sequencer: bench-side ROM and ALU, programs
// loaded between resets, outputs sampled on the falling clock edge.
module tb_bytecode_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [5:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [7:0] result;
  logic       out_valid;
  logic [7:0] out_data;
  logic       running, halted, illegal;

  logic [7:0] rom [256];
  logic [7:0] prog [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         prints;
  logic [7:0] last_print;

  bytecode_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .result     (result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .running    (running),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  // op 0 = add, op 1 = subtract, anything else = xor
  assign alu_result = (alu_op == 6'd0) ? alu_a + alu_b :
                      (alu_op == 6'd1) ? alu_a - alu_b : alu_a ^ alu_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int max_cyc);
    int cyc;
    cyc        = 0;
    prints     = 0;
    last_print = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(halted || illegal) && cyc < max_cyc) begin
      if (out_valid) begin
        prints++;
        last_print = out_data;
      end
      @(negedge clk);
      cyc++;
    end
    check("run_timeout", (cyc < max_cyc), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_running"},   running,   0);
    check({tag, "_halted"},    halted,    0);
    check({tag, "_illegal"},   illegal,   0);
    check({tag, "_result"},    result,    0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_alu"},       {alu_op, alu_a, alu_b}, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
  endtask

  initial begin
    int n;

    // Reset state and HLT timing: halted rises exactly after the 4th edge.
    prog = '{8'hFF};
    load_prog();
    do_reset();
    check_reset_outputs("rst");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hlt_e3_running", running, 1);
    check("hlt_e3_halted", halted, 0);
    @(negedge clk);
    check("hlt_e4_halted", halted, 1);
    check("hlt_e4_running", running, 0);
    n = 0;
    repeat (5) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    check("hlt_no_print", n, 0);
    check("hlt_pc", imem_addr, 8'h01);

    // ALU2 add 5+3, then print dmem[2].
    prog = '{8'h02, 8'h00, 8'h05, 8'h03, 8'h81, 8'h02, 8'hFF};
    load_prog();
    do_reset();
    run(100);
    check("alu2_result", result, 8'h08);
    check("alu2_prints", prints, 1);
    check("alu2_out", last_print, 8'h08);
    check("alu2_halted", halted, 1);

    // ALU1 subtract reuses alu_b=3 from the preceding ALU2: 9-3=6.
    prog = '{8'h02, 8'h00, 8'h05, 8'h03, 8'h01, 8'h01, 8'h09, 8'h81, 8'h02, 8'hFF};
    load_prog();
    do_reset();
    run(100);
    check("alu1_result", result, 8'h06);
    check("alu1_out", last_print, 8'h06);
    check("alu1_b_held", alu_b, 8'h03);

    // STI then MOV then PRN of the moved byte.
    prog = '{8'hC2, 8'h10, 8'h2A, 8'hE2, 8'h11, 8'h10, 8'h81, 8'h11, 8'hFF};
    load_prog();
    do_reset();
    run(100);
    check("mov_prints", prints, 1);
    check("mov_out", last_print, 8'h2A);
    check("mov_result", result, 8'h2A);

    // CALL to 5, print dmem[2] (reset value 0), RET back to address 2 = HLT.
    prog = '{8'hAA, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h81, 8'h02, 8'h55};
    load_prog();
    do_reset();
    run(100);
    check("call_prints", prints, 1);
    check("call_out", last_print, 8'h00);
    check("call_halted", halted, 1);
    check("call_ret_pc", imem_addr, 8'h03);

    // RET without link is a no-op; 0x3C is illegal and held despite start.
    prog = '{8'h55, 8'h3C};
    load_prog();
    do_reset();
    run(100);
    check("ill_illegal", illegal, 1);
    check("ill_running", running, 0);
    check("ill_halted", halted, 0);
    check("ill_pc", imem_addr, 8'h02);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ill_held", {illegal, running, imem_addr}, {1'b1, 1'b0, 8'h02});

    // Reset during EXEC of STI must not write dmem[0x20].
    prog = '{8'hC2, 8'h20, 8'h11, 8'hFF};
    load_prog();
    do_reset();
    run(100);
    prog = '{8'hC2, 8'h20, 8'h77, 8'hFF};
    load_prog();
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dut.state_q != S_EXEC && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_exec", (n < 50), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    prog = '{8'h81, 8'h20, 8'hFF};
    load_prog();
    run(100);
    check("abort_prints", prints, 1);
    check("abort_dmem_kept", last_print, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
